// File: rtl/carregador_operandos_pkg.sv
// -----------------------------------------------------------------------------
// carregador_operandos_pkg
//
// Shared definitions for the operand loader:
//   - estado_t : FSM state codes, also shown on the LEDs (code 2'b11 unused)
//   - CONT_W   : width of the debounce counter
//   - estado_proximo() : state reached after an accepted key press
// -----------------------------------------------------------------------------
package carregador_operandos_pkg;

    // Debounce counter width; holds any DEBOUNCE_CYCLES up to 2^20-1.
    localparam int CONT_W = 20;

    typedef enum logic [1:0] {
        ESPERA_A = 2'b00,
        ESPERA_B = 2'b01,
        PRONTO   = 2'b10
    } estado_t;

    // Sequence of the loader: A -> B -> ready -> A. Any unknown code,
    // including 2'b11, returns to ESPERA_A.
    function automatic estado_t estado_proximo(input estado_t atual);
        case (atual)
            ESPERA_A: estado_proximo = ESPERA_B;
            ESPERA_B: estado_proximo = PRONTO;
            default:  estado_proximo = ESPERA_A;
        endcase
    endfunction

endpackage

// File: rtl/carregador_operandos_debounce_tecla.sv
// -----------------------------------------------------------------------------
// debounce_tecla
//
// Turns the raw, active-low pushbutton into a single-cycle press pulse.
//   KEY -> two-flop synchronizer -> counter-based debouncer -> falling-edge
//   detector -> pulso (registered).
//
// Ports:
//   CLOCK_50 : system clock, all state on its rising edge
//   reset    : synchronous, active-high
//   KEY      : raw asynchronous pushbutton (0 = pressed)
//   pulso    : high for exactly one cycle per accepted press
//
// Latency: if KEY is first sampled low at edge N and stays low, pulso is
// high in the cycle following edge N+DEBOUNCE_CYCLES+2.
// -----------------------------------------------------------------------------
module debounce_tecla
    import carregador_operandos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic KEY,
    output logic pulso
);

    localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              nivel_q, nivel_d;          // debounced level
    logic              nivel_ant_q, nivel_ant_d;  // debounced level, one cycle old
    logic [CONT_W-1:0] cont_q, cont_d;
    logic [1:0]        sync_ok_q, sync_ok_d;      // synchronizer refilled since reset
    logic              armado_q, armado_d;        // key seen released since reset
    logic              pulso_q, pulso_d;

    // NOTE: every variable gets a default at the top of the always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sync1_d     = KEY;
        sync2_d     = sync1_q;
        nivel_d     = nivel_q;
        nivel_ant_d = nivel_q;
        cont_d      = cont_q;
        sync_ok_d   = {sync_ok_q[0], 1'b1};

        if (sync2_q == nivel_q) begin
            cont_d = '0;
        end else if (cont_q == LIMITE) begin
            nivel_d = sync2_q;
            cont_d  = '0;
        end else begin
            cont_d = cont_q + CONT_W'(1);
        end

        // The synchronizer resets to "released", so right after reset its
        // output says nothing about the real key. Only once it holds real
        // samples and shows the key up (and debounced up) is a press
        // allowed to count. A key held through reset therefore never
        // produces a pulse until it is released and pressed again.
        armado_d = armado_q | (sync_ok_q[1] & sync2_q & nivel_q);

        // Debounced 1->0 only; the release edge produces nothing.
        pulso_d = armado_q & nivel_ant_q & ~nivel_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            nivel_q     <= 1'b1;
            nivel_ant_q <= 1'b1;
            cont_q      <= '0;
            sync_ok_q   <= '0;
            armado_q    <= 1'b0;
            pulso_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            nivel_q     <= nivel_d;
            nivel_ant_q <= nivel_ant_d;
            cont_q      <= cont_d;
            sync_ok_q   <= sync_ok_d;
            armado_q    <= armado_d;
            pulso_q     <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/carregador_operandos.sv
// -----------------------------------------------------------------------------
// carregador_operandos
//
// Loads the operands of a 4-bit adder from switches, one key press per step:
//   press 1 : A   <= SW[3:0]
//   press 2 : B   <= SW[3:0], TE0 <= SW[4]   (valido rises)
//   press 3 : A, B, TE0 cleared              (back to waiting for A)
//
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   KEY      : raw pushbutton, active-low
//   SW[4:0]  : SW[3:0] operand value, SW[4] carry-in
//   A, B     : registered operands
//   TE0      : registered carry-in
//   valido   : registered, high while the state is PRONTO
//   estado   : current state code for the LEDs
//
// Outputs change on the edge after the debounced press pulse.
// -----------------------------------------------------------------------------
module carregador_operandos
    import carregador_operandos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEY,
    input  logic [4:0] SW,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       TE0,
    output logic       valido,
    output logic [1:0] estado
);

    logic       pulso;

    estado_t    estado_q, estado_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       te0_q, te0_d;
    logic       valido_q, valido_d;

    debounce_tecla #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .KEY     (KEY),
        .pulso   (pulso)
    );

    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        te0_d    = te0_q;

        case (estado_q)
            ESPERA_A: begin
                if (pulso) begin
                    a_d      = SW[3:0];
                    estado_d = estado_proximo(estado_q);
                end
            end
            ESPERA_B: begin
                if (pulso) begin
                    b_d      = SW[3:0];
                    te0_d    = SW[4];
                    estado_d = estado_proximo(estado_q);
                end
            end
            PRONTO: begin
                if (pulso) begin
                    a_d      = '0;
                    b_d      = '0;
                    te0_d    = 1'b0;
                    estado_d = estado_proximo(estado_q);
                end
            end
            default: begin
                // Illegal code: recover unconditionally, operands untouched.
                estado_d = ESPERA_A;
            end
        endcase

        // Derived from the next state so valido rises together with PRONTO.
        valido_d = (estado_d == PRONTO);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado_q <= ESPERA_A;
            a_q      <= '0;
            b_q      <= '0;
            te0_q    <= 1'b0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            te0_q    <= te0_d;
            valido_q <= valido_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign TE0    = te0_q;
    assign valido = valido_q;
    assign estado = estado_q;

endmodule

// File: tb/tb_carregador_operandos.sv
// -----------------------------------------------------------------------------
// tb_carregador_operandos
//
// Self-checking bench for carregador_operandos with DEBOUNCE_CYCLES = 4.
// Table of press vectors, randomized presses/glitches against a small
// step-counting model, and hand sequences for latency, glitch rejection,
// held key, reset interactions and illegal-state recovery.
// -----------------------------------------------------------------------------
module tb_carregador_operandos;
    import carregador_operandos_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       KEY;
    logic [4:0] SW;
    logic [3:0] A, B;
    logic       TE0, valido;
    logic [1:0] estado;

    int checks   = 0;
    int failures = 0;
    int pulse_count = 0;

    // Reference model: number of accepted presses since reset (mod 3)
    // plus the values the operands should hold.
    int         m_passo;
    logic [3:0] m_a, m_b;
    logic       m_te0;

    carregador_operandos #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .KEY     (KEY),
        .SW      (SW),
        .A       (A),
        .B       (B),
        .TE0     (TE0),
        .valido  (valido),
        .estado  (estado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_debounce.pulso === 1'b1) pulse_count++;
    end

    typedef struct {
        logic [4:0] sw;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_te0;
        logic       exp_valido;
        logic [1:0] exp_estado;
    } vetor_t;

    vetor_t tabela [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [3:0] ea, input logic [3:0] eb,
                              input logic et, input logic ev, input logic [1:0] ee);
        check({name, ".A"}, 32'(A), 32'(ea));
        check({name, ".B"}, 32'(B), 32'(eb));
        check({name, ".TE0"}, 32'(TE0), 32'(et));
        check({name, ".valido"}, 32'(valido), 32'(ev));
        check({name, ".estado"}, 32'(estado), 32'(ee));
    endtask

    task automatic check_model(input string name);
        logic [1:0] ee;
        ee = (m_passo == 0) ? 2'b00 : (m_passo == 1) ? 2'b01 : 2'b10;
        check_outs(name, m_a, m_b, m_te0, (m_passo == 2), ee);
    endtask

    task automatic model_reset();
        m_passo = 0;
        m_a = '0;
        m_b = '0;
        m_te0 = 1'b0;
    endtask

    task automatic model_press(input logic [4:0] sw);
        case (m_passo)
            0: m_a = sw[3:0];
            1: begin m_b = sw[3:0]; m_te0 = sw[4]; end
            default: begin m_a = '0; m_b = '0; m_te0 = 1'b0; end
        endcase
        m_passo = (m_passo + 1) % 3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        KEY   = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        model_reset();
    endtask

    // Full press: held long enough to be accepted, then a debounced release.
    task automatic press(input logic [4:0] sw);
        SW  = sw;
        KEY = 1'b0;
        repeat (D + 6) tick();
        KEY = 1'b1;
        repeat (D + 6) tick();
    endtask

    initial begin
        int p0;
        logic [4:0] sw;

        reset = 1'b1;
        KEY   = 1'b1;
        SW    = '0;
        repeat (3) tick();
        check_outs("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        repeat (8) tick();
        model_reset();
        check_outs("idle_after_reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

        // ---------------- table-driven press sequence ----------------
        tabela[0] = '{5'b0_0011, 4'h3, 4'h0, 1'b0, 1'b0, 2'b01};
        tabela[1] = '{5'b1_0101, 4'h3, 4'h5, 1'b1, 1'b1, 2'b10};
        tabela[2] = '{5'b1_1111, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00};
        tabela[3] = '{5'b0_1111, 4'hF, 4'h0, 1'b0, 1'b0, 2'b01};
        tabela[4] = '{5'b0_0000, 4'hF, 4'h0, 1'b0, 1'b1, 2'b10};
        tabela[5] = '{5'b1_0000, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00};
        tabela[6] = '{5'b1_1010, 4'hA, 4'h0, 1'b0, 1'b0, 2'b01};
        tabela[7] = '{5'b1_1001, 4'hA, 4'h9, 1'b1, 1'b1, 2'b10};
        for (int i = 0; i < 8; i++) begin
            press(tabela[i].sw);
            check_outs($sformatf("tab%0d", i), tabela[i].exp_a, tabela[i].exp_b,
                       tabela[i].exp_te0, tabela[i].exp_valido, tabela[i].exp_estado);
            // Switches moving without a press must not disturb anything.
            SW = 5'($urandom);
            repeat (5) tick();
            check_outs($sformatf("tab%0d_hold", i), tabela[i].exp_a, tabela[i].exp_b,
                       tabela[i].exp_te0, tabela[i].exp_valido, tabela[i].exp_estado);
            model_press(tabela[i].sw);
        end

        // ---------------- randomized presses / glitches ----------------
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    sw = 5'($urandom);
                    press(sw);
                    model_press(sw);
                end
                1: begin
                    SW  = 5'($urandom);
                    KEY = 1'b0;
                    repeat ($urandom_range(1, D - 1)) tick();
                    KEY = 1'b1;
                    repeat (D + 4) tick();
                end
                default: begin
                    SW = 5'($urandom);
                    repeat (5) tick();
                end
            endcase
            check_model($sformatf("rnd%0d", it));
        end

        // ---------------- glitch of 2 cycles ----------------
        do_reset();
        p0  = pulse_count;
        KEY = 1'b0;
        repeat (2) tick();
        KEY = 1'b1;
        repeat (15) tick();
        check("glitch.pulses", 32'(pulse_count - p0), 32'd0);
        check("glitch.estado", 32'(estado), 32'd0);

        // ---------------- exact latency, then key held ----------------
        p0  = pulse_count;
        SW  = 5'b0_0110;
        KEY = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();  // tick k is edge N+k-1
            check($sformatf("lat.pulso_k%0d", k), 32'(dut.u_debounce.pulso), 32'(k == 7));
            check($sformatf("lat.A_k%0d", k), 32'(A), (k >= 8) ? 32'h6 : 32'h0);
        end
        repeat (30) tick();
        check("held.pulses", 32'(pulse_count - p0), 32'd1);
        check("held.estado", 32'(estado), 32'd1);
        KEY = 1'b1;
        repeat (D + 6) tick();

        // ---------------- reset in the pulse cycle ----------------
        SW  = 5'b1_0111;
        KEY = 1'b0;
        repeat (7) tick();
        check("dom.pulso_now", 32'(dut.u_debounce.pulso), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("dom", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        repeat (20) tick();
        check("dom.held_estado", 32'(estado), 32'd0);
        KEY = 1'b1;
        repeat (D + 6) tick();

        // ---------------- reset in ESPERA_B with key held ----------------
        do_reset();
        press(5'b0_0010);
        check("rst36.pre_estado", 32'(estado), 32'd1);
        KEY = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        p0 = pulse_count;
        repeat (20) tick();
        check_outs("rst36.after", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        check("rst36.pulses", 32'(pulse_count - p0), 32'd0);
        KEY = 1'b1;
        repeat (D + 6) tick();
        check("rst36.release_estado", 32'(estado), 32'd0);
        press(5'b0_0100);
        check_outs("rst36.repress", 4'h4, 4'h0, 1'b0, 1'b0, 2'b01);

        // ---------------- illegal state recovery ----------------
        force dut.estado_q = estado_t'(2'b11);
        #1;
        check("ilegal.forced", 32'(estado), 32'd3);
        #1;
        release dut.estado_q;
        tick();
        check("ilegal.recover", 32'(estado), 32'd0);
        check("ilegal.A_kept", 32'(A), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carregador_operandos.md
CARREGADOR_OPERANDOS -- requirements
Module: carregador_operandos

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clock cycles needed to accept a KEY level change (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 KEY  input  1  raw asynchronous pushbutton; active-low (0 = pressed).
REQ-005 SW  input  5  SW[3:0] = operand value, SW[4] = carry-in value.
REQ-006 A  output  4  registered operand A for the 4-bit adder.
REQ-007 B  output  4  registered operand B for the 4-bit adder.
REQ-008 TE0  output  1  registered carry-in for the adder.
REQ-009 valido  output  1  high while A, B and TE0 form a complete operand set.
REQ-010 estado  output  2  current FSM state code, for LED display.

Function
REQ-011 KEY shall pass through a two-flop synchronizer before any other use.
REQ-012 The debouncer shall hold a debounced level, reset value 1, and a 20-bit counter, reset value 0.
REQ-013 Counter: clears whenever the synchronized KEY equals the debounced level; otherwise increments.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level shall take the synchronized value and the counter shall clear.
REQ-015 A press pulse shall be high for exactly one cycle on each debounced 1->0 transition; the 0->1 transition shall not produce a pulse.
REQ-016 Latency: the pulse shall be high in cycle N+DEBOUNCE_CYCLES+2, where N is the first edge sampling KEY low, provided KEY stays low throughout.
REQ-017 Any KEY glitch shorter than DEBOUNCE_CYCLES cycles after synchronization shall produce no pulse.
REQ-018 FSM states and codes: ESPERA_A=00, ESPERA_B=01, PRONTO=10; code 11 is illegal and shall return to ESPERA_A on the next edge.
REQ-019 ESPERA_A with pulse: A <= SW[3:0]; next state ESPERA_B.
REQ-020 ESPERA_B with pulse: B <= SW[3:0]; TE0 <= SW[4]; next state PRONTO.
REQ-021 PRONTO with pulse: A, B and TE0 clear to 0; next state ESPERA_A.
REQ-022 Without a pulse, state, A, B and TE0 shall hold; SW changes shall have no effect on the outputs.
REQ-023 valido shall equal (state == PRONTO), registered, and shall rise in the same cycle the state enters PRONTO.
REQ-024 Outputs shall update on the edge after the pulse cycle, i.e. one cycle after the pulse.
REQ-025 Holding KEY low indefinitely shall yield exactly one pulse, so only one state advance occurs.

Reset
REQ-026 On reset: state=ESPERA_A, A=0, B=0, TE0=0, valido=0, estado=00, debounced level=1, counter=0, synchronizer flops=1.
REQ-027 Reset shall dominate any simultaneous pulse.
REQ-028 Reset asserted mid-debounce or mid-sequence shall discard all partial progress; no pulse shall follow reset release unless KEY is released and then pressed again.

Structure
REQ-029 A shared package shall hold the state codes ESPERA_A, ESPERA_B, PRONTO and the counter width constant (20).
REQ-030 Synchronizer, debounce and edge detect shall form one sub-module, debounce_tecla (ports CLOCK_50, reset, KEY, pulso); the FSM and operand registers shall be in the top level.

Verification
REQ-031 The bench shall use DEBOUNCE_CYCLES=4 for all directed scenarios.
REQ-032 SW=5'b0_0011, press; SW=5'b1_0101, press -> A=3, B=5, TE0=1, valido=1, estado=10.
REQ-033 KEY low for 2 cycles, then high -> no pulse; estado stays 00.
REQ-034 KEY low from edge N, held -> pulse only in cycle N+6; A updates at N+7.
REQ-035 From PRONTO, press -> A=0, B=0, TE0=0, valido=0, estado=00.
REQ-036 Reset asserted in ESPERA_B with KEY held low -> estado=00 after reset, and no advance until KEY is released and pressed again.
REQ-037 Force estado to 11 -> estado=00 on the next edge.
